// File: rtl/jtopl_slot_regs_pkg.sv
// Shared constants and decode helpers for the OPL slot register file.
package jtopl_slot_regs_pkg;

    localparam int SLOTS = 18;
    localparam int CHANS = 9;

    localparam logic [7:0] A_NTS   = 8'h08;
    localparam logic [7:0] A_OP_AM = 8'h20;
    localparam logic [7:0] A_OP_TL = 8'h40;
    localparam logic [7:0] A_OP_AD = 8'h60;
    localparam logic [7:0] A_OP_SR = 8'h80;
    localparam logic [7:0] A_FNUM  = 8'hA0;
    localparam logic [7:0] A_KON   = 8'hB0;
    localparam logic [7:0] A_DEPTH = 8'hBD;

    localparam int B_NTS   = 6;
    localparam int B_DEPTH = 7;
    localparam int B_AM    = 7;
    localparam int B_EGT   = 5;
    localparam int B_KSR   = 4;
    localparam int B_KEYON = 5;

    typedef struct packed {
        logic       vld;
        logic [4:0] slot;
    } op_dec_t;

    // Operator offset -> slot; sub 6/7 and group 3 are holes in the map.
    function automatic op_dec_t op_decode(input logic [4:0] off);
        op_dec_t d;
        d.vld  = (off[4:3] != 2'd3) && (off[2:0] <= 3'd5);
        d.slot = {3'd0, off[4:3]} * 5'd6 + {2'd0, off[2:0]};
        return d;
    endfunction

    function automatic logic [3:0] slot2ch(input logic [4:0] slot);
        logic [4:0] grp;
        logic [4:0] sub;
        grp = slot / 5'd6;
        sub = slot % 5'd6;
        return 4'(grp * 5'd3 + sub % 5'd3);
    endfunction

endpackage

// File: rtl/jtopl_sh.sv
// Clock-enabled shift register used for the EG stage alignment delays.
module jtopl_sh #(
    parameter int W      = 1,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] drop
);
    logic [STAGES-1:0][W-1:0] bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (cen) begin
            bits[0] <= din;
            for (int i = 1; i < STAGES; i++) bits[i] <= bits[i-1];
        end
    end

    assign drop = bits[STAGES-1];
endmodule

// File: rtl/jtopl_slot_cnt.sv
// Slot sequencer: counts 0..SLOTS-1 on cenop and decodes the upcoming slot's channel.
module jtopl_slot_cnt #(
    parameter int SLOTS = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    output logic [4:0] nxt_slot,
    output logic [3:0] nxt_ch,
    output logic       zero
);
    import jtopl_slot_regs_pkg::slot2ch;

    logic [4:0] cnt;

    assign nxt_slot = (cnt == 5'(SLOTS - 1)) ? 5'd0 : cnt + 5'd1;
    assign nxt_ch   = slot2ch(nxt_slot);
    assign zero     = (cnt == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (cenop) cnt <= nxt_slot;
    end
endmodule

// File: rtl/jtopl_slot_regs.sv
// OPL register file: CPU address/data writes in, per-slot EG configuration replayed out.
module jtopl_slot_regs #(
    parameter int SLOTS = jtopl_slot_regs_pkg::SLOTS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cenop,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic       zero,
    output logic       keyon_I,
    output logic       en_sus_I,
    output logic [3:0] arate_I,
    output logic [3:0] drate_I,
    output logic [3:0] rrate_I,
    output logic [3:0] sl_I,
    output logic [9:0] fnum_I,
    output logic [2:0] block_I,
    output logic       ksr_II,
    output logic [3:0] keycode_II,
    output logic       amsen_IV,
    output logic       ams_IV,
    output logic [5:0] tl_IV,
    output logic [1:0] ksl_IV
);
    import jtopl_slot_regs_pkg::*;

    logic [7:0] sel_addr;
    logic       nts, depth;

    logic [SLOTS-1:0]      am_r, egt_r, ksr_r;
    logic [SLOTS-1:0][1:0] ksl_r;
    logic [SLOTS-1:0][5:0] tl_r;
    logic [SLOTS-1:0][3:0] ar_r, dr_r, sl_r, rr_r;
    logic [CHANS-1:0][9:0] fnum_r;
    logic [CHANS-1:0][2:0] blk_r;
    logic [CHANS-1:0]      kon_r;

    logic       wr;
    op_dec_t    od;
    logic [3:0] ch_w;
    logic       ch_ok;

    assign wr    = cen & ~cs_n & ~wr_n;
    assign od    = op_decode(sel_addr[4:0]);
    assign ch_w  = sel_addr[3:0];
    assign ch_ok = (ch_w <= 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_addr <= '0;
            nts      <= 1'b0;
            depth    <= 1'b0;
            am_r     <= '0;
            egt_r    <= '0;
            ksr_r    <= '0;
            ksl_r    <= '0;
            tl_r     <= '0;
            ar_r     <= '0;
            dr_r     <= '0;
            sl_r     <= '0;
            rr_r     <= '0;
            fnum_r   <= '0;
            blk_r    <= '0;
            kon_r    <= '0;
        end else if (wr) begin
            if (!addr) begin
                sel_addr <= din;
            end else begin
                if (sel_addr == A_NTS)   nts   <= din[B_NTS];
                if (sel_addr == A_DEPTH) depth <= din[B_DEPTH];
                if (od.vld) begin
                    case (sel_addr[7:5])
                        A_OP_AM[7:5]: begin
                            am_r[od.slot]  <= din[B_AM];
                            egt_r[od.slot] <= din[B_EGT];
                            ksr_r[od.slot] <= din[B_KSR];
                        end
                        A_OP_TL[7:5]: begin
                            ksl_r[od.slot] <= din[7:6];
                            tl_r[od.slot]  <= din[5:0];
                        end
                        A_OP_AD[7:5]: begin
                            ar_r[od.slot] <= din[7:4];
                            dr_r[od.slot] <= din[3:0];
                        end
                        A_OP_SR[7:5]: begin
                            sl_r[od.slot] <= din[7:4];
                            rr_r[od.slot] <= din[3:0];
                        end
                        default: ;
                    endcase
                end
                if (ch_ok && sel_addr[7:4] == A_FNUM[7:4]) fnum_r[ch_w][7:0] <= din;
                if (ch_ok && sel_addr[7:4] == A_KON[7:4]) begin
                    kon_r[ch_w]       <= din[B_KEYON];
                    blk_r[ch_w]       <= din[4:2];
                    fnum_r[ch_w][9:8] <= din[1:0];
                end
            end
        end
    end

    logic [4:0] nxt_slot;
    logic [3:0] nxt_ch;

    jtopl_slot_cnt #(.SLOTS(SLOTS)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .nxt_slot (nxt_slot),
        .nxt_ch   (nxt_ch),
        .zero     (zero)
    );

    logic       ksr_I, am_I, ams_I;
    logic [3:0] kc_I;
    logic [5:0] tl_I;
    logic [1:0] ksl_I;

    // Storage is read with the pre-edge value, so a same-edge write shows up next lap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyon_I  <= 1'b0;
            en_sus_I <= 1'b0;
            arate_I  <= '0;
            drate_I  <= '0;
            rrate_I  <= '0;
            sl_I     <= '0;
            fnum_I   <= '0;
            block_I  <= '0;
            ksr_I    <= 1'b0;
            kc_I     <= '0;
            am_I     <= 1'b0;
            ams_I    <= 1'b0;
            tl_I     <= '0;
            ksl_I    <= '0;
        end else if (cenop) begin
            keyon_I  <= kon_r[nxt_ch];
            en_sus_I <= egt_r[nxt_slot];
            arate_I  <= ar_r[nxt_slot];
            drate_I  <= dr_r[nxt_slot];
            rrate_I  <= rr_r[nxt_slot];
            sl_I     <= sl_r[nxt_slot];
            fnum_I   <= fnum_r[nxt_ch];
            block_I  <= blk_r[nxt_ch];
            ksr_I    <= ksr_r[nxt_slot];
            kc_I     <= {blk_r[nxt_ch], nts ? fnum_r[nxt_ch][8] : fnum_r[nxt_ch][9]};
            am_I     <= am_r[nxt_slot];
            ams_I    <= depth;
            tl_I     <= tl_r[nxt_slot];
            ksl_I    <= ksl_r[nxt_slot];
        end
    end

    jtopl_sh #(.W(5), .STAGES(1)) u_sh_ii (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cenop),
        .din   ({ksr_I, kc_I}),
        .drop  ({ksr_II, keycode_II})
    );

    jtopl_sh #(.W(10), .STAGES(3)) u_sh_iv (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cenop),
        .din   ({am_I, ams_I, tl_I, ksl_I}),
        .drop  ({amsen_IV, ams_IV, tl_IV, ksl_IV})
    );
endmodule

// File: doc/jtopl_slot_regs.md
Name: jtopl_slot_regs

Overview:
- CPU-side register file and slot sequencer for the OPL core.
- Accepts the OPL2 address/data write protocol and stores the per-operator and per-channel parameters.
- Replays those parameters one slot per cenop in the fixed 18-slot order. It drives the stage I/II/IV envelope-configuration inputs that the envelope generator reads, plus its zero pulse.
- Sits between the bus wrapper and the EG/PG datapath; it is the writer end of the EG's configuration interface.

Parameters:
- SLOTS, 18, number of time-multiplexed operator slots; the slot counter wraps at SLOTS-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  bus clock enable; writes are sampled only when high
- cenop  in  1  operator clock enable; advances the slot sequence
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- addr  in  1  0 = address port, 1 = data port
- din  in  8  bus write data
- zero  out  1  high while slot 0 is presented at stage I
- keyon_I  out  1  key-on of this slot's channel
- en_sus_I  out  1  EGT bit (sustain enable)
- arate_I / drate_I / rrate_I / sl_I  out  4 each  AR, DR, RR, SL nibbles
- fnum_I  out  10  channel F-number
- block_I  out  3  channel block
- ksr_II  out  1  KSR bit, delayed one cenop
- keycode_II  out  4  {block, fnum[9] if nts=0 else fnum[8]}, delayed one cenop
- amsen_IV  out  1  AM enable bit, delayed three cenop
- ams_IV  out  1  AM depth (reg 0xBD bit7), delayed three cenop
- tl_IV  out  6  total level, delayed three cenop
- ksl_IV  out  2  key-scale level, delayed three cenop

Behaviour:
- Reset (rst_n low, asynchronous):
  - All storage, the selected address, nts, am depth and all outputs are cleared.
  - The slot counter is cleared to 0.
  - zero reads 1 after release, since slot 0 is presented first.
- Bus write:
  - Acts on the clk edge where cen and !cs_n and !wr_n are all high.
  - addr=0 latches din into sel_addr.
  - addr=1 writes din to the register named by sel_addr; sel_addr is retained, so repeated data writes hit the same register.
  - Writes are level-sampled; the bus wrapper guarantees one-cen-wide strobes.
- Operator register decode, for sel_addr in 0x20-0x35, 0x40-0x55, 0x60-0x75, 0x80-0x95:
  - off = sel_addr[4:0]; grp = off[4:3]; sub = off[2:0].
  - Valid only if grp<=2 and sub<=5; slot = grp*6 + sub.
  - Offsets with sub 6/7 or grp 3 are silently ignored.
  - 0x20 holds AM/VIB/EGT/KSR/MULT, 0x40 holds KSL[7:6]/TL[5:0], 0x60 holds AR/DR, 0x80 holds SL/RR.
- Channel register decode, for 0xA0-0xA8 and 0xB0-0xB8:
  - Channel = sel_addr[3:0], valid when <=8.
  - 0xAx writes fnum[7:0]; 0xBx writes keyon (bit5), block (bits 4:2) and fnum[9:8].
  - Channels 9-15 are ignored.
- Global registers: 0x08 bit6 = nts; 0xBD bit7 = am depth. All other addresses are ignored with no side effect.
- Slot sequence:
  - On each cenop the counter advances 0..SLOTS-1 and then wraps to 0.
  - Stage I outputs are registered from storage on the same cenop edge.
  - Channel of a slot = grp*3 + (sub mod 3), where grp = slot/6 and sub = slot mod 6.
- Pipeline alignment: stage II outputs are the stage I values delayed by one cenop; stage IV outputs are delayed by three cenop, each matched to the same slot.
- Write/read collision: if a write and a cenop read of the same slot occur on one edge, the old value is output and the new value appears on the next lap (18 cenop later).
- Key-on is per channel and is presented on both operator slots of the channel. Edge detection is owned by the EG; this block only holds the level.
- cenop low: the counter and outputs hold; bus writes continue.

Decomposition:
- Shared package constants: SLOTS; register base addresses 0x08, 0x20, 0x40, 0x60, 0x80, 0xA0, 0xB0, 0xBD; field bit positions.
- The slot-to-channel mapping function also belongs in the package.
- One natural sub-module, jtopl_slot_cnt: the slot counter, zero generation and the grp/sub/channel decode.
- The stage delays reuse the existing jtopl_sh shift register.

Test Plan:
- Reset release with no writes -> zero high at the first slot; zero pulses every 18 cenop; all parameter outputs are 0.
- Write 0x60 then 0xF2 -> at slot 0, arate_I=0xF and drate_I=0x2; all other slots stay 0.
- Write 0x95 then 0x3A -> slot 17 shows sl_I=3, rrate_I=0xA. Write 0x86 then 0xFF -> no slot changes.
- Write 0xA3=0x41 and 0xB3=0x2D -> slots 6 and 9 show keyon_I=1, block_I=3, fnum_I=0x141. keycode_II=0x6 with nts=0; after 0x08=0x40, keycode_II=0x7 on the next lap.
- Write 0x48=0x85 and 0x28=0x90 -> at slot 6, tl_IV=5, ksl_IV=2, amsen_IV=1 appear three cenop after slot 6 is presented at stage I. Write 0xBD=0x80 -> ams_IV=1.
- Assert rst_n low mid-lap, at slot 11 -> outputs and storage clear asynchronously; after release the sequence restarts at slot 0 with zero=1.
